// File: rtl/ds1307_i2c_target.sv
// ds1307_i2c_target: I2C target emulating the DS1307 RTC register map (regs 0x00-0x07) with a BCD seconds/minutes/hours clock
// Ports: clk, rst_n (async, active-low); scl_in/sda_in raw pad inputs; sda_oe pulls SDA low (pad: sda = sda_oe ? 1'b0 : 1'bz);
//        sec_tick one-clk pulse per second; time_sec/time_min/time_hour registered copies of regs 0-2; busy from address match to START/STOP
module ds1307_i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h68,
    parameter int         NUM_REGS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       sec_tick,
    output logic [7:0] time_sec,
    output logic [7:0] time_min,
    output logic [7:0] time_hour,
    output logic       busy
);
    localparam int PW = $clog2(NUM_REGS);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_PTR       = 4'd3;
    localparam logic [3:0] S_PTR_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RDATA_ACK = 4'd8;
    localparam logic [3:0] S_WAIT      = 4'd9;

    logic [2:0]    scl_q, scl_d, sda_q, sda_d;
    logic [3:0]    state_q, state_d, cnt_q, cnt_d;
    logic [7:0]    sr_q, sr_d;
    logic [PW-1:0] ptr_q, ptr_d, ptr_nx;
    logic          rw_q, rw_d, oe_q, oe_d, busy_q, busy_d;
    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    regs_d [NUM_REGS];
    logic [7:0]    time_sec_q, time_min_q, time_hour_q;
    logic          scl, sda, scl_rise, scl_fall, start, stop, wr_en, load, tick, c_sec, c_min;
    logic [7:0]    byte_in, nsec, nmin, nhour;

    // Seconds/minutes: a units digit above 9 counts as 9; returns {carry, next}
    function automatic logic [8:0] inc60(input logic [7:0] v);
        logic [3:0] u;
        u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        if (u != 4'd9) return {1'b0, v[7:4], u + 4'd1};
        if (v[6:4] >= 3'd5) return 9'h100;
        return {1'b0, v[7], v[6:4] + 3'd1, 4'd0};
    endfunction

    // 24h hours: 23 wraps to 00, which also clears bit6
    function automatic logic [7:0] inc24(input logic [7:0] v);
        logic [3:0] u;
        u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        if (v[5:4] >= 2'd2 && u >= 4'd3) return 8'h00;
        if (u != 4'd9) return {v[7:4], u + 4'd1};
        return {v[7:6], v[5:4] + 2'd1, 4'd0};
    endfunction

    // scl_q[1]/sda_q[1] are the synchronised levels, [2] the previous sample
    assign scl      = scl_q[1];
    assign sda      = sda_q[1];
    assign scl_rise = scl & ~scl_q[2];
    assign scl_fall = ~scl & scl_q[2];
    assign start    = scl & scl_q[2] & sda_q[2] & ~sda;
    assign stop     = scl & scl_q[2] & ~sda_q[2] & sda;
    assign byte_in  = {sr_q[6:0], sda};
    assign ptr_nx   = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + PW'(1);
    assign tick     = sec_tick & ~regs_q[0][7];
    assign {c_sec, nsec} = inc60(regs_q[0]);
    assign {c_min, nmin} = inc60(regs_q[1]);
    assign nhour    = inc24(regs_q[2]);

    always_comb begin
        scl_d   = {scl_q[1:0], scl_in};
        sda_d   = {sda_q[1:0], sda_in};
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        ptr_d   = ptr_q;
        rw_d    = rw_q;
        oe_d    = oe_q;
        wr_en   = 1'b0;
        load    = 1'b0;
        if (start) begin
            state_d = S_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (stop) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: if (scl_rise) begin
                    sr_d  = byte_in;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = 4'd0;
                        if (state_q == S_ADDR) begin
                            rw_d    = byte_in[0];
                            state_d = (byte_in[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_WAIT;
                        end else if (state_q == S_PTR) begin
                            ptr_d   = PW'(int'(byte_in) % NUM_REGS);
                            state_d = S_PTR_ACK;
                        end else begin
                            wr_en   = 1'b1;
                            ptr_d   = ptr_nx;
                            state_d = S_WDATA_ACK;
                        end
                    end
                end
                // cnt 0: waiting for the 8th fall to drive ACK; cnt 1: 9th rise seen, next fall ends ACK
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_rise) cnt_d = 4'd1;
                    else if (scl_fall && cnt_q == 4'd0) oe_d = 1'b1;
                    else if (scl_fall) begin
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = (state_q == S_ADDR_ACK) ? S_PTR : S_WDATA;
                        load    = (state_q == S_ADDR_ACK) && rw_q;
                    end
                end
                S_RDATA: begin
                    if (scl_rise) cnt_d = cnt_q + 4'd1;
                    else if (scl_fall && cnt_q == 4'd8) begin
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = S_RDATA_ACK;
                    end else if (scl_fall) begin
                        sr_d = {sr_q[6:0], sr_q[7]};
                        oe_d = ~sr_q[6];
                    end
                end
                S_RDATA_ACK: begin
                    if (scl_rise) begin
                        cnt_d = 4'd1;
                        if (sda) state_d = S_WAIT;
                    end else if (scl_fall && cnt_q == 4'd1) load = 1'b1;
                end
                default: ;
            endcase
        end
        // Transmit byte is a snapshot taken here; later ticks leave it alone
        if (load) begin
            sr_d    = regs_q[ptr_q];
            oe_d    = ~regs_q[ptr_q][7];
            ptr_d   = ptr_nx;
            cnt_d   = 4'd0;
            state_d = S_RDATA;
        end
        regs_d = regs_q;
        if (tick) begin
            regs_d[0] = nsec;
            if (c_sec) regs_d[1] = nmin;
            if (c_sec && c_min) regs_d[2] = nhour;
        end
        // Applied after the tick so a same-cycle I2C write to that register wins
        if (wr_en) regs_d[ptr_q] = byte_in;
        busy_d = !(state_q inside {S_IDLE, S_ADDR, S_WAIT});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q       <= '1;
            sda_q       <= '1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            regs_q      <= '{default: '0};
            time_sec_q  <= '0;
            time_min_q  <= '0;
            time_hour_q <= '0;
        end else begin
            scl_q       <= scl_d;
            sda_q       <= sda_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            regs_q      <= regs_d;
            time_sec_q  <= regs_q[0];
            time_min_q  <= regs_q[1];
            time_hour_q <= regs_q[2];
        end
    end

    assign sda_oe    = oe_q;
    assign busy      = busy_q;
    assign time_sec  = time_sec_q;
    assign time_min  = time_min_q;
    assign time_hour = time_hour_q;
endmodule

// File: tb/tb_ds1307_i2c_target.sv
// tb_ds1307_i2c_target: randomized I2C master plus register/clock model checking ds1307_i2c_target
module tb_ds1307_i2c_target;
    localparam int Q = 50;

    logic       clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_sda = 1'b1, sec_tick = 1'b0;
    logic       sda_oe, busy, sda_bus, watch = 1'b0, seen = 1'b0;
    logic [7:0] time_sec, time_min, time_hour;
    logic [7:0] mregs [8];
    logic [7:0] wbuf [16];
    int         mptr = 0, checks = 0, errors = 0;

    assign sda_bus = m_sda & ~sda_oe;

    ds1307_i2c_target dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
        .sec_tick(sec_tick), .time_sec(time_sec), .time_min(time_min), .time_hour(time_hour), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) seen <= watch ? (seen | sda_oe) : 1'b0;

    initial begin
        #950_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bcd(input logic [6:0] v);
        int u;
        u = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return int'(v[6:4]) * 10 + u;
    endfunction

    function automatic logic [7:0] tobcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic m_tick();
        int s, m, h;
        if (mregs[0][7]) return;
        s = bcd(mregs[0][6:0]) + 1;
        if (s < 60) mregs[0] = tobcd(s);
        else begin
            mregs[0] = 8'h00;
            m = bcd(mregs[1][6:0]) + 1;
            if (m < 60) mregs[1] = tobcd(m);
            else begin
                mregs[1] = 8'h00;
                h = bcd({1'b0, mregs[2][5:0]}) + 1;
                mregs[2] = (h < 24) ? tobcd(h) : 8'h00;
            end
        end
    endtask

    function automatic logic [7:0] rand_reg(input int idx);
        int t;
        case (idx)
            0: return {1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 5)), 4'($urandom_range(0, 15))};
            1: return {1'b0, 3'($urandom_range(0, 5)), 4'($urandom_range(0, 15))};
            2: begin
                t = $urandom_range(0, 2);
                return {2'b00, 2'(t), 4'((t == 2) ? $urandom_range(0, 3) : $urandom_range(0, 15))};
            end
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic tick();
        sec_tick = 1'b1;
        #10;
        sec_tick = 1'b0;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_sda = 1'b0; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_sda = 1'b1; #Q;
        #Q;
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; #Q;
            scl = 1'b1;   #(2 * Q);
            scl = 1'b0;   #Q;
        end
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        ack = sda_bus; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #Q; scl = 1'b1;
            #Q; b[i] = sda_bus;
            #Q; scl = 1'b0;
            #Q;
        end
        m_sda = nack; #Q;
        scl = 1'b1;   #(2 * Q);
        scl = 1'b0;   #Q;
    endtask

    task automatic check_time(input string tag);
        check({tag, "_sec"}, time_sec, mregs[0]);
        check({tag, "_min"}, time_min, mregs[1]);
        check({tag, "_hour"}, time_hour, mregs[2]);
    endtask

    task automatic do_write(input int ptr, input int n);
        logic a;
        i2c_start();
        wbyte(8'hD0, a);
        check("ack_addr_w", a, 1'b0);
        check("busy_xfer", busy, 1'b1);
        wbyte(8'(ptr), a);
        check("ack_ptr", a, 1'b0);
        mptr = ptr % 8;
        for (int i = 0; i < n; i++) begin
            wbyte(wbuf[i], a);
            check($sformatf("ack_data[%0d]", i), a, 1'b0);
            mregs[mptr] = wbuf[i];
            mptr = (mptr + 1) % 8;
        end
        i2c_stop();
        check("busy_stop_w", busy, 1'b0);
    endtask

    task automatic do_read(input bit set_ptr, input int ptr, input int n);
        logic a;
        logic [7:0] b;
        i2c_start();
        if (set_ptr) begin
            wbyte(8'hD0, a);
            check("ack_addr_w", a, 1'b0);
            wbyte(8'(ptr), a);
            check("ack_ptr", a, 1'b0);
            mptr = ptr % 8;
            i2c_start();
        end
        wbyte(8'hD1, a);
        check("ack_addr_r", a, 1'b0);
        for (int i = 0; i < n; i++) begin
            rbyte(i == n - 1, b);
            check($sformatf("rd_data[%0d]", mptr), b, mregs[mptr]);
            mptr = (mptr + 1) % 8;
        end
        check("rd_release", sda_oe, 1'b0);
        i2c_stop();
        check("busy_stop_r", busy, 1'b0);
    endtask

    initial begin
        logic a;
        int n, p;
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        #100;
        rst_n = 1'b1;
        #100;
        check("rst_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check_time("rst");

        wbuf = '{8'h00, 8'h40, 8'h50, 8'h03, 8'h28, 8'h07, 8'h21, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0};
        do_write(0, 8);
        check("t1_ptr_wrap", mptr, 0);
        check("t1_min", time_min, 8'h40);
        check_time("t1");
        do_read(0, 0, 1);
        do_read(1, 0, 8);

        watch = 1'b1;
        i2c_start();
        wbyte(8'hD2, a);
        check("nak_addr", a, 1'b1);
        wbyte(8'h00, a);
        check("nak_data", a, 1'b1);
        check("nak_busy", busy, 1'b0);
        check("nak_oe", seen, 1'b0);
        watch = 1'b0;
        i2c_stop();
        do_read(1, 0, 8);

        wbuf[0] = 8'h59; wbuf[1] = 8'h59; wbuf[2] = 8'h23;
        do_write(0, 3);
        tick();
        m_tick();
        #20;
        check("t4_sec", time_sec, 8'h00);
        check("t4_hour", time_hour, 8'h00);
        check_time("t4");
        do_read(1, 3, 1);

        wbuf[0] = 8'h80;
        do_write(0, 1);
        repeat (5) begin
            tick();
            m_tick();
        end
        #20;
        check("t5_halt", time_sec, 8'h80);
        wbuf[0] = 8'h00;
        do_write(0, 1);
        tick();
        m_tick();
        #20;
        check("t5_run", time_sec, 8'h01);

        wbuf[0] = 8'h17;
        do_write(0, 1);
        fork
            do_read(1, 0, 1);
            begin
                #(126 * Q);
                tick();
            end
        join
        m_tick();
        check("snap_sec", time_sec, 8'h18);
        check_time("snap");

        repeat (25) begin
            case ($urandom_range(0, 3))
                0: begin
                    p = $urandom_range(0, 255);
                    n = $urandom_range(1, 9);
                    for (int i = 0; i < n; i++) wbuf[i] = rand_reg((p + i) % 8);
                    do_write(p, n);
                end
                1: do_read(1, $urandom_range(0, 255), $urandom_range(1, 9));
                2: do_read(0, 0, $urandom_range(1, 4));
                default: repeat ($urandom_range(1, 3)) begin
                    tick();
                    m_tick();
                    #20;
                end
            endcase
            #20;
            check_time("rnd");
        end

        wbuf[0] = 8'h00;
        do_write(5, 1);
        i2c_start();
        wbyte(8'hD0, a);
        wbyte(8'h05, a);
        i2c_start();
        wbyte(8'hD1, a);
        m_sda = 1'b1;
        repeat (3) begin
            #Q; scl = 1'b1;
            #(2 * Q); scl = 1'b0;
        end
        #Q;
        check("t6_drive", sda_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_oe", sda_oe, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        #9;
        scl = 1'b1;
        #(2 * Q);
        rst_n = 1'b1;
        #(2 * Q);
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        mptr = 0;
        check_time("t6");
        do_read(0, 0, 2);
        do_read(1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
